// File: rtl/spfifo_arb_pkg.sv
// Shared types for the FIFO push arbiter.
//   arb_state_t : arbiter state (idle/re-arbitrating vs. holding a burst lock)
package spfifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/spfifo_push_arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first asserted request found when searching from `start`
// upward, wrapping modulo NREQ (also correct for non power-of-two NREQ).
// Ports:
//   req    in  NREQ : request vector
//   start  in  IDW  : first index to examine (must be < NREQ)
//   winner out IDW  : index of the first asserted request (0 when none)
//   any    out 1    : at least one request asserted
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  // One extra bit so start+k never overflows before the modulo fold.
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, start} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!any && req[idx[IDW-1:0]]) begin
        any    = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/spfifo_push_arb.sv
// Round-robin push arbiter in front of the write side of a single-port,
// dual-bank FIFO. One requester is granted per cycle; a winner may keep the
// port for up to BURST consecutive pushes so sequential writes stream across
// both banks. Grant/push/wdata/req_ack are combinational (zero latency).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | no lock held; arbitrate from ptr every cycle
// ARB_LOCK | own holds the port; cnt pushes done in the current burst
//
// Ports:
//   clk       in  1          : clock, rising edge
//   rst_n     in  1          : asynchronous active-low reset
//   req       in  NREQ       : requester i has a word pending
//   req_data  in  NREQ*WIDTH : word of requester i at [i*WIDTH +: WIDTH]
//   req_ack   out NREQ       : one-hot/zero, word of requester i consumed
//   fifo_full in  1          : FIFO full
//   push      out 1          : FIFO push
//   wdata     out WIDTH      : FIFO write data (0 when not pushing)
//   locked    out 1          : arbiter is in ARB_LOCK
//   owner     out IDW        : current or last granted requester
module spfifo_push_arb
  import spfifo_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  input  logic                  fifo_full,
  output logic                  push,
  output logic [WIDTH-1:0]      wdata,
  output logic                  locked,
  output logic [IDW-1:0]        owner
);

  localparam int CW = $clog2(BURST+1);
  localparam logic [CW-1:0] BURST_W = CW'(BURST);

  arb_state_t     st, st_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [IDW-1:0] own, own_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic [IDW-1:0] start;
  logic [IDW-1:0] win;
  logic           any;
  logic           rearb;
  logic           push_c;
  logic [IDW-1:0] grant;
  logic [CW-1:0]  cnt_inc;

  function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ-1)) ? '0 : i + 1'b1;
  endfunction

  // A lock whose owner has dropped req is released and re-arbitrated in the
  // same cycle, starting just after the old owner.
  assign rearb   = (st == ARB_IDLE) || !req[own];
  assign start   = (st == ARB_IDLE) ? ptr : inc_idx(own);
  assign cnt_inc = cnt + 1'b1;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .start  (start),
    .winner (win),
    .any    (any)
  );

  always_comb begin
    st_n   = st;
    ptr_n  = ptr;
    own_n  = own;
    cnt_n  = cnt;
    push_c = 1'b0;
    grant  = own;
    if (rearb) begin
      if (st == ARB_LOCK) begin
        st_n  = ARB_IDLE;
        ptr_n = inc_idx(own);
        cnt_n = '0;
      end
      if (any && !fifo_full) begin
        push_c = 1'b1;
        grant  = win;
        own_n  = win;
        if (BURST == 1) begin
          st_n  = ARB_IDLE;
          ptr_n = inc_idx(win);
          cnt_n = '0;
        end else begin
          st_n  = ARB_LOCK;
          cnt_n = CW'(1);
        end
      end
    end else if (!fifo_full) begin
      // fifo_full with the owner still requesting just stalls: lock is kept.
      push_c = 1'b1;
      cnt_n  = cnt_inc;
      if (cnt_inc == BURST_W) begin
        st_n  = ARB_IDLE;
        ptr_n = inc_idx(own);
        cnt_n = '0;
      end
    end
  end

  // Outputs are forced quiet during reset so nothing is acked that the
  // requester will re-present afterwards.
  assign push    = push_c & rst_n;
  assign req_ack = push ? (NREQ'(1) << grant) : '0;
  assign wdata   = push ? req_data[grant*WIDTH +: WIDTH] : '0;
  assign locked  = (st == ARB_LOCK);
  assign owner   = own;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ARB_IDLE;
      ptr <= '0;
      own <= '0;
      cnt <= '0;
    end else begin
      st  <= st_n;
      ptr <= ptr_n;
      own <= own_n;
      cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_spfifo_push_arb.sv
module tb_spfifo_push_arb;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic                  fifo_full;
  logic                  push;
  logic [WIDTH-1:0]      wdata;
  logic                  locked;
  logic [1:0]            owner;

  int n_cmp = 0;
  int n_err = 0;

  spfifo_push_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .fifo_full (fifo_full),
    .push      (push),
    .wdata     (wdata),
    .locked    (locked),
    .owner     (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int src);
    chk({tag, "_push"}, 32'(push), 32'd1);
    chk({tag, "_ack"}, 32'(req_ack), 32'(1 << src));
    chk({tag, "_wdata"}, 32'(wdata), 32'h0000A000 + 32'(src));
  endtask

  task automatic exp_none(input string tag);
    chk({tag, "_push"}, 32'(push), 32'd0);
    chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
  endtask

  task automatic exp_state(input string tag, input logic lk, input int own);
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
    chk({tag, "_owner"}, 32'(owner), 32'(own));
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 16'hA000 + 16'(i);

    // Reset: outputs quiet even with all requesters asking.
    #1 req = 4'b1111;
    #1 exp_none("rst_gate");
    exp_state("rst", 1'b0, 0);
    req = 4'b0000;
    @(negedge clk) rst_n = 1'b1;

    repeat (5) begin
      tick();
      exp_none("noreq");
      exp_state("noreq", 1'b0, 0);
    end

    // All requesting: bursts of 4 rotating 0,1,2,3,0 with no idle cycle.
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      #1 exp_push($sformatf("rr%0d", c), (c / 4) % 4);
      tick();
    end
    exp_state("rr_end", 1'b1, 0);
    req = 4'b0000;
    #1 exp_none("rr_drop");
    tick();
    exp_state("rr_drop", 1'b0, 0);

    // ptr=1. Requester 2 alone for two acks, then hands over to 3.
    req = 4'b0100;
    #1 exp_push("r2a", 2);
    tick();
    #1 exp_push("r2b", 2);
    tick();
    exp_state("r2", 1'b1, 2);
    req = 4'b1000;
    #1 exp_push("r3_same_cycle", 3);
    tick();
    exp_state("r3", 1'b1, 3);
    req = 4'b0000;
    #1 exp_none("r3_drop");
    tick();
    exp_state("r3_drop", 1'b0, 3);

    // ptr=0. Requester 1 bursts; FIFO full for 3 cycles at cnt=2.
    req = 4'b0010;
    #1 exp_push("r1a", 1);
    tick();
    #1 exp_push("r1b", 1);
    tick();
    exp_state("r1", 1'b1, 1);
    fifo_full = 1'b1;
    req = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1 exp_none($sformatf("stall%0d", c));
      tick();
      exp_state($sformatf("stall%0d", c), 1'b1, 1);
    end
    fifo_full = 1'b0;
    #1 exp_push("r1c", 1);
    tick();
    #1 exp_push("r1d", 1);
    tick();
    exp_state("r1_done", 1'b0, 1);
    #1 exp_push("to_r2", 2);
    tick();
    exp_state("to_r2", 1'b1, 2);
    req = 4'b0000;
    #1 exp_none("r2_drop");
    tick();

    // ptr=3. FIFO full while idle.
    req = 4'b0100;
    fifo_full = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1 exp_none($sformatf("idlefull%0d", c));
      tick();
      exp_state($sformatf("idlefull%0d", c), 1'b0, 2);
    end
    fifo_full = 1'b0;
    #1 exp_push("idlefull_go", 2);
    tick();
    exp_state("idlefull_go", 1'b1, 2);
    req = 4'b0000;
    #1 exp_none("idlefull_drop");
    tick();

    // ptr=3. Reset in the middle of requester 3's burst.
    req = 4'b1000;
    #1 exp_push("r3ra", 3);
    tick();
    #1 exp_push("r3rb", 3);
    tick();
    exp_push("r3rc_pre", 3);
    exp_state("r3rc_pre", 1'b1, 3);
    #1 rst_n = 1'b0;
    #1 exp_none("rst_mid");
    exp_state("rst_mid", 1'b0, 0);
    req = 4'b1001;
    #1 rst_n = 1'b1;
    #1 exp_push("after_rst", 0);
    tick();
    exp_state("after_rst", 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spfifo_push_arb.md
# spfifo_push_arb

Round-robin push arbiter that shares the write port of one single-port, dual-bank FIFO between NREQ producers. It picks one requester per cycle and drives the FIFO `push`/`wdata`. A granted requester may hold the port for up to BURST consecutive pushes, which keeps sequential writes streaming across both banks. The block sits directly in front of the FIFO's write side; the read side is untouched.

## Interface
- `WIDTH`, 16: data width, equal to the FIFO WIDTH.
- `NREQ`, 4: number of requesters, 2..16.
- `BURST`, 4: maximum consecutive pushes per grant, ≥1; 1 gives pure round-robin.
- `IDW`, $clog2(NREQ): requester index width (derived).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: requester i has a word pending; must hold until acked.
- `req_data`  in  NREQ*WIDTH: word of requester i at bits [i*WIDTH +: WIDTH].
- `req_ack`  out  NREQ: one-hot or zero; the word of requester i is consumed this cycle.
- `fifo_full`  in  1: FIFO `full`.
- `push`  out  1: FIFO push.
- `wdata`  out  WIDTH: FIFO wdata.
- `locked`  out  1: state is ARB_LOCK.
- `owner`  out  IDW: current or last granted requester.

## Operation
- State: `st` ∈ {ARB_IDLE, ARB_LOCK}; `ptr` (IDW): round-robin start index; `own` (IDW); `cnt` ($clog2(BURST+1) bits): pushes in the current burst.
- Pick: the first i with `req[i]`=1, searching ptr, ptr+1, … mod NREQ.
- ARB_IDLE, or ARB_LOCK with `req[own]`=0 (release-and-rearbitrate in the same cycle, pick from ptr=own+1):
  - No request, or `fifo_full`=1: push=0. An ARB_LOCK entry goes to ARB_IDLE with ptr←own+1.
  - Otherwise grant winner w:
    - push=1, wdata=req_data[w], req_ack[w]=1, own←w.
    - If BURST=1: stay/go ARB_IDLE, ptr←w+1.
    - Else: go ARB_LOCK, cnt←1.
- ARB_LOCK with `req[own]`=1:
  - `fifo_full`=1: push=0. State, own and cnt hold (stall keeps the lock).
  - Else: push=1, wdata=req_data[own], req_ack[own]=1, cnt←cnt+1.
    - If cnt+1 == BURST: go ARB_IDLE, ptr←own+1, cnt←0.
- Invariants:
  - push=0 whenever fifo_full=1, so every push is accepted by the FIFO.
  - At most one req_ack bit is set; req_ack ≠ 0 ⇔ push=1.
  - wdata=0 when push=0.
- Index arithmetic is modulo NREQ and wraps from NREQ-1 to 0, including when NREQ is not a power of two.

## Timing
- Grant, push, wdata and req_ack are combinational from req, fifo_full and registered state: zero-cycle latency.
- st, ptr, own and cnt update on the rising clk edge.
- Reset values: st=ARB_IDLE, ptr=0, own=0, cnt=0, locked=0.
- While rst_n=0, push=0, req_ack=0 and wdata=0 regardless of req.
- Reset asserted mid-burst aborts the burst. The word being presented is not acked and is re-requested after reset.
- A requester may change req_data only in the cycle after its ack.
- Sustained throughput is one push per cycle while the FIFO is not full.

## Structure
- Package `spfifo_arb_pkg`: `arb_state_t` enum {ARB_IDLE, ARB_LOCK}.
- Sub-module `rr_pick` (combinational): inputs req vector and start index; outputs winner index and `any`. Instantiated once, with start = ptr or own+1.
- The FIFO is not instantiated inside this block; both are wired together at the level above.

## Test plan
All scenarios use NREQ=4, BURST=4, WIDTH=16.
- Reset, then req=4'b0000 for 5 cycles → push=0, locked=0, owner=0.
- req=4'b1111 held, data 0xA000+i, FIFO never full → pushes come from requester 0 ×4, then 1 ×4, 2 ×4, 3 ×4, 0 …; no idle cycles.
- Requester 2 alone, releases req after 2 acks, requester 3 requesting → requester 3 is pushed in the cycle req[2] drops; ptr=3.
- fifo_full=1 for 3 cycles mid-burst (cnt=2, owner=1) → push=0 and req_ack=0 during the stall; then 2 more pushes from requester 1; then release to requester 2.
- fifo_full=1 while idle with req=4'b0100 → no push, locked=0; full drops → push 0x?? from requester 2, locked=1 the next cycle.
- rst_n pulsed low mid-burst (owner=3, cnt=2) → push and req_ack are 0 immediately and asynchronously; after release st=ARB_IDLE and ptr=0, so requester 0 wins if requesting.
